// File: rtl/multicycle_state_ctrl.sv
// multicycle_state_ctrl: multicycle MIPS control FSM with halt latch, run/step gate and retire/cycle counters
module multicycle_state_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic             run_mode,
  input  logic             step,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);
  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_AEXE = 3'b110, S_BEXE = 3'b101,
    S_CEXE = 3'b010, S_MEM = 3'b011, S_AWB = 3'b111, S_CWB = 3'b100
  } state_t;
  localparam logic [5:0] OP_LW = 6'b110001, OP_HALT = 6'b111111;
  state_t cur, nxt;
  logic is_a, is_b, is_c, is_j, is_h, adv, illegal;
  assign is_a = opcode inside {6'b000010, 6'b010010, 6'b011000, 6'b000000, 6'b000001,
                               6'b100000, 6'b100111, 6'b010000, 6'b010001};
  assign is_b = opcode == 6'b110100;
  assign is_c = opcode inside {6'b110000, OP_LW};
  assign is_j = opcode inside {6'b111000, 6'b111001, 6'b111010};
  assign is_h = opcode == OP_HALT;
  assign adv = (run_mode | step) & ~halted;
  assign illegal = ~(is_a | is_b | is_c | is_j | is_h);
  assign state = cur;
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:   nxt = S_ID;
      S_ID:   nxt = is_a ? S_AEXE : is_b ? S_BEXE : is_c ? S_CEXE : S_IF;
      S_AEXE: nxt = S_AWB;
      S_CEXE: nxt = S_MEM;
      S_MEM:  nxt = opcode == OP_LW ? S_CWB : S_IF;
      default: nxt = S_IF;
    endcase
  end
  // illegal_op is a pulse, so it is rewritten every cycle rather than held with adv
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cur        <= S_IF;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      instr_cnt  <= '0;
      cycle_cnt  <= '0;
    end else begin
      illegal_op <= adv && cur == S_ID && illegal;
      if (adv) begin
        cur       <= nxt;
        cycle_cnt <= cycle_cnt + 1'b1;
        if (cur != S_IF && nxt == S_IF) instr_cnt <= instr_cnt + 1'b1;
        if (cur == S_ID && is_h) halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_state_ctrl.sv
// tb_multicycle_state_ctrl: table-driven vectors plus directed step/halt/illegal/reset sequences
module tb_multicycle_state_ctrl;
  logic        CLK = 0;
  logic        RST = 0;
  logic [5:0]  opcode = 6'b0;
  logic        run_mode = 0;
  logic        step = 0;
  logic [2:0]  state;
  logic        halted, illegal_op;
  logic [31:0] instr_cnt, cycle_cnt;
  int checks = 0;
  int errors = 0;

  localparam logic [5:0] ADD = 6'b000000, ORI = 6'b010010, LW = 6'b110001, SW = 6'b110000,
                         BEQ = 6'b110100, JMP = 6'b111000, HALT = 6'b111111, BAD = 6'b101010;

  multicycle_state_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .run_mode(run_mode), .step(step),
    .state(state), .halted(halted), .illegal_op(illegal_op),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        run;
    logic        stp;
    logic [5:0]  op;
    logic [2:0]  st;
    logic        h;
    logic        il;
    logic [31:0] ic;
    logic [31:0] cc;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic h, input logic il,
                         input logic [31:0] ic, input logic [31:0] cc);
    chk({tag, ".state"}, {29'b0, state}, {29'b0, st});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
    chk({tag, ".illegal_op"}, {31'b0, illegal_op}, {31'b0, il});
    chk({tag, ".instr_cnt"}, instr_cnt, ic);
    chk({tag, ".cycle_cnt"}, cycle_cnt, cc);
  endtask

  task automatic do_reset();
    RST = 0;
    tick();
    RST = 1;
  endtask

  initial begin
    v[0]  = '{0, 1, 0, ADD, 3'b000, 0, 0, 0, 0};
    v[1]  = '{1, 1, 0, ADD, 3'b001, 0, 0, 0, 1};
    v[2]  = '{1, 1, 0, ADD, 3'b110, 0, 0, 0, 2};
    v[3]  = '{1, 1, 0, ADD, 3'b111, 0, 0, 0, 3};
    v[4]  = '{1, 1, 0, ADD, 3'b000, 0, 0, 1, 4};
    v[5]  = '{1, 1, 0, LW,  3'b001, 0, 0, 1, 5};
    v[6]  = '{1, 1, 0, LW,  3'b010, 0, 0, 1, 6};
    v[7]  = '{1, 1, 0, LW,  3'b011, 0, 0, 1, 7};
    v[8]  = '{1, 1, 0, LW,  3'b100, 0, 0, 1, 8};
    v[9]  = '{1, 1, 0, LW,  3'b000, 0, 0, 2, 9};
    v[10] = '{1, 1, 0, SW,  3'b001, 0, 0, 2, 10};
    v[11] = '{1, 1, 0, SW,  3'b010, 0, 0, 2, 11};
    v[12] = '{1, 1, 0, SW,  3'b011, 0, 0, 2, 12};
    v[13] = '{1, 1, 0, SW,  3'b000, 0, 0, 3, 13};
    v[14] = '{1, 1, 0, BEQ, 3'b001, 0, 0, 3, 14};
    v[15] = '{1, 1, 0, BEQ, 3'b101, 0, 0, 3, 15};
    v[16] = '{1, 1, 0, BEQ, 3'b000, 0, 0, 4, 16};
    v[17] = '{1, 1, 0, JMP, 3'b001, 0, 0, 4, 17};
    v[18] = '{1, 1, 0, JMP, 3'b000, 0, 0, 5, 18};
    v[19] = '{0, 1, 0, ADD, 3'b000, 0, 0, 0, 0};
    v[20] = '{1, 0, 0, ORI, 3'b000, 0, 0, 0, 0};
    v[21] = '{1, 0, 1, ORI, 3'b001, 0, 0, 0, 1};
    #1;
    for (int i = 0; i < 22; i++) begin
      RST = v[i].rst; run_mode = v[i].run; step = v[i].stp; opcode = v[i].op;
      tick();
      chk_all($sformatf("vec%0d", i), v[i].st, v[i].h, v[i].il, v[i].ic, v[i].cc);
    end
    step = 0;

    // single-step: three one-cycle pulses five cycles apart
    do_reset();
    run_mode = 0; opcode = ORI;
    for (int p = 0; p < 3; p++) begin
      logic [2:0] exp_st;
      exp_st = p == 0 ? 3'b001 : p == 1 ? 3'b110 : 3'b111;
      step = 1;
      tick();
      step = 0;
      chk($sformatf("step%0d.state", p), {29'b0, state}, {29'b0, exp_st});
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("step%0d.hold%0d", p, k), {29'b0, state}, {29'b0, exp_st});
      end
    end
    chk("step.cycle_cnt", cycle_cnt, 32'd3);
    run_mode = 1;
    tick();
    chk("step.runswitch", {29'b0, state}, 32'd0);
    chk("step.instr_cnt", instr_cnt, 32'd1);

    // halt: freeze for 20 cycles with step toggling, then reset clears
    do_reset();
    run_mode = 1; opcode = HALT;
    tick();
    chk_all("halt.id", 3'b001, 0, 0, 0, 1);
    tick();
    chk_all("halt.if", 3'b000, 1, 0, 1, 2);
    for (int k = 0; k < 20; k++) begin
      step = k[0];
      run_mode = k[1];
      opcode = ADD;
      tick();
      chk($sformatf("halt.frz%0d.state", k), {29'b0, state}, 32'd0);
      chk($sformatf("halt.frz%0d.cyc", k), cycle_cnt, 32'd2);
      chk($sformatf("halt.frz%0d.h", k), {31'b0, halted}, 32'd1);
    end
    step = 0; run_mode = 1;
    RST = 0;
    tick();
    chk_all("halt.rst", 3'b000, 0, 0, 0, 0);
    RST = 1;

    // illegal opcode: one-cycle pulse and counted as retired
    do_reset();
    run_mode = 1; opcode = BAD;
    tick();
    chk_all("ill.id", 3'b001, 0, 0, 0, 1);
    tick();
    chk_all("ill.if", 3'b000, 0, 1, 1, 2);
    tick();
    chk_all("ill.next", 3'b001, 0, 0, 1, 3);

    // illegal pulse must drop even when the FSM stalls right after it
    do_reset();
    opcode = BAD;
    tick();
    run_mode = 0;
    step = 1;
    tick();
    step = 0;
    chk("ill.stall.pulse", {31'b0, illegal_op}, 32'd1);
    tick();
    chk("ill.stall.drop", {31'b0, illegal_op}, 32'd0);
    run_mode = 1;

    // reset asserted while in MEM
    do_reset();
    opcode = SW;
    for (int k = 0; k < 3; k++) tick();
    chk("rstmem.pre", {29'b0, state}, 32'd3);
    RST = 0;
    tick();
    chk_all("rstmem.post", 3'b000, 0, 0, 0, 0);
    RST = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
